miriscv_mdu: RTL and testbench
==============================

MIRISCV_MDU -- requirements
Module: miriscv_mdu

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, meaning operand and result width.
REQ-002 Port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 Port mdu_req_i, input, 1 bit: operation request, qualified by mdu_ready_o.
REQ-005 Port mdu_op_i, input, 3 bits, with the following encoding:
- 0 MUL
- 1 MULH
- 2 MULHSU
- 3 MULHU
- 4 DIV
- 5 DIVU
- 6 REM
- 7 REMU
REQ-006 Ports mdu_port_a_i and mdu_port_b_i, inputs, XLEN bits each: rs1/rs2 operands.
REQ-007 Port mdu_kill_i, input, 1 bit: pipeline flush; aborts any operation.
REQ-008 Port mdu_ready_o, output, 1 bit: unit can accept a request this cycle.
REQ-009 Port mdu_valid_o, output, 1 bit: mdu_result_o is valid this cycle (one-cycle pulse).
REQ-010 Port mdu_result_o, output, XLEN bits: operation result.

Function
REQ-011 The FSM SHALL have the states IDLE, MUL, DIV and DONE.
REQ-012 mdu_ready_o SHALL be 1 only in IDLE; mdu_valid_o SHALL be 1 only in DONE.
REQ-013 Acceptance SHALL occur when mdu_req_i and mdu_ready_o are both 1 and mdu_kill_i is 0.
- On acceptance, operands and op are latched.
- Ops 0-3 go to MUL; ops 4-7 go to DIV.
REQ-014 MUL SHALL be radix-2 shift-add on a 2*XLEN accumulator.
- Signed/unsigned operand extension follows op.
- Exactly XLEN iteration cycles, then DONE.
REQ-015 MUL and MULH*/MULHU SHALL select the low and high XLEN bits of the 2*XLEN product, respectively.
REQ-016 DIV SHALL be a restoring divider on operand magnitudes.
- Exactly XLEN iteration cycles, then DONE.
- Quotient is negated when operand signs differ (DIV only).
- Remainder takes the dividend's sign (REM only).
REQ-017 Division by zero SHALL give quotient all-ones and remainder = dividend, for all four division ops.
REQ-018 Signed overflow (DIV/REM with a = 0x8000_0000, b = 0xFFFF_FFFF) SHALL give quotient 0x8000_0000 and remainder 0.
REQ-019 Latency SHALL be fixed as follows.
- Accepted at edge N: mdu_valid_o = 1 in cycle N+XLEN+1.
- The next cycle returns to IDLE.
- Minimum initiation interval is XLEN+2 cycles.
REQ-020 DONE SHALL last exactly one cycle; no backpressure exists.
REQ-021 mdu_result_o SHALL hold the last result until the next DONE and SHALL be 0 after reset.
REQ-022 mdu_kill_i = 1 in any state SHALL force IDLE at the next edge.
- No mdu_valid_o pulse follows.
- A kill in DONE does not suppress the current valid pulse.
REQ-023 A kill in the same cycle as a request SHALL drop that request.
REQ-024 mdu_req_i outside IDLE SHALL be ignored; the latched operands SHALL not change mid-operation.

Reset
REQ-025 rst_i = 1 SHALL immediately set the following, independent of clk_i:
- state = IDLE, iteration counter = 0, mdu_valid_o = 0;
- mdu_result_o = 0, internal accumulators = 0;
- mdu_ready_o = 1.
REQ-026 Reset asserted mid-operation SHALL discard the operation; no valid pulse SHALL follow deassertion.

Configuration
REQ-027 Macro MIRISCV_MDU_EARLY_OUT_EN SHALL control the early-out path.
- Defined: division by zero, signed overflow, and any MUL/DIV with b = 0 skip iteration and go IDLE -> DONE directly (valid in cycle N+1).
- Undefined: all ops take the full latency of REQ-019.
REQ-028 Result values SHALL be identical with and without MIRISCV_MDU_EARLY_OUT_EN.

Verification
REQ-029 MUL a=7, b=-3 -> valid at N+33, result 0xFFFF_FFEB; MULHU a=b=0xFFFF_FFFF -> 0xFFFF_FFFE.
REQ-030 DIV a=-7, b=2 -> 0xFFFF_FFFD; REM same operands -> 0xFFFF_FFFF; REMU a=7, b=2 -> 1.
REQ-031 DIVU a=5, b=0 -> 0xFFFF_FFFF; REM a=5, b=0 -> 5; DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000.
- Latency: N+1 with MIRISCV_MDU_EARLY_OUT_EN, N+33 without.
REQ-032 Kill asserted 10 cycles after acceptance -> ready at next cycle, no valid pulse; new MUL 3*4 accepted -> 12.
REQ-033 rst_i pulsed asynchronously mid-DIV -> outputs reset with no clock edge; no stale valid afterwards.
REQ-034 Back-to-back requests held high -> exactly one valid per XLEN+2 cycles; results match a reference model for 1000 random ops.

Source files
------------

// File: rtl/miriscv_mdu.sv
// Iterative RISC-V M-extension unit: radix-2 shift-add multiplier and restoring divider.
// Optional macro MIRISCV_MDU_EARLY_OUT_EN lets trivial cases (b = 0, signed overflow) skip iteration.
module miriscv_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            mdu_req_i,
  input  logic [2:0]      mdu_op_i,
  input  logic [XLEN-1:0] mdu_port_a_i,
  input  logic [XLEN-1:0] mdu_port_b_i,
  input  logic            mdu_kill_i,
  output logic            mdu_ready_o,
  output logic            mdu_valid_o,
  output logic [XLEN-1:0] mdu_result_o
);

  localparam int            CW        = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);
  localparam logic [2:0]    OP_MUL    = 3'd0;
  localparam logic [2:0]    OP_MULH   = 3'd1;
  localparam logic [2:0]    OP_MULHU  = 3'd3;
  localparam logic [2:0]    OP_DIV    = 3'd4;
  localparam logic [2:0]    OP_REM    = 3'd6;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [2:0]         r_op;
  logic [XLEN-1:0]    r_a;
  logic [XLEN-1:0]    r_b;
  logic [2*XLEN-1:0]  r_mcand;
  logic [2*XLEN-1:0]  r_acc;
  logic [CW-1:0]      r_cnt;
  logic [XLEN-1:0]    r_result;

  logic               w_accept;
  logic               w_early;
  logic               w_last;
  logic               w_in_div_signed;
  logic               w_mul_a_sext;
  logic [XLEN-1:0]    w_a_abs;
  logic [XLEN-1:0]    w_b_abs;
  logic [XLEN:0]      w_div_diff;
  logic [2*XLEN-1:0]  w_acc_step;
  logic [2*XLEN-1:0]  w_early_acc;
  logic [2:0]         w_res_op;
  logic [XLEN-1:0]    w_res_a;
  logic [XLEN-1:0]    w_res_b;
  logic [2*XLEN-1:0]  w_res_acc;
  logic [XLEN-1:0]    w_quo_raw;
  logic [XLEN-1:0]    w_rem_raw;
  logic [XLEN-1:0]    w_quo;
  logic [XLEN-1:0]    w_rem;
  logic [XLEN-1:0]    w_result;

  assign w_accept        = (r_state == IDLE) && mdu_req_i && !mdu_kill_i;
  assign w_last          = (r_cnt == LAST_ITER);
  assign w_in_div_signed = (mdu_op_i == OP_DIV) || (mdu_op_i == OP_REM);
  assign w_mul_a_sext    = mdu_port_a_i[XLEN-1] && (mdu_op_i != OP_MULHU);
  assign w_a_abs = (w_in_div_signed && mdu_port_a_i[XLEN-1]) ? -mdu_port_a_i : mdu_port_a_i;
  assign w_b_abs = (w_in_div_signed && mdu_port_b_i[XLEN-1]) ? -mdu_port_b_i : mdu_port_b_i;

`ifdef MIRISCV_MDU_EARLY_OUT_EN
  assign w_early = (mdu_port_b_i == '0) ||
                   (w_in_div_signed && (mdu_port_a_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (mdu_port_b_i == '1));
`else
  assign w_early = 1'b0;
`endif

  // Raw accumulator that yields the right answer once fed through the sign/zero fix-up below
  assign w_early_acc = (mdu_port_b_i == '0) ? '0 : {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};

  always_comb begin
    w_state_next = r_state;
    mdu_ready_o  = 1'b0;
    mdu_valid_o  = 1'b0;
    case (r_state)
      IDLE: begin
        mdu_ready_o = 1'b1;
        if (w_accept) w_state_next = w_early ? DONE : (mdu_op_i[2] ? DIV : MUL);
      end
      MUL, DIV: if (w_last) w_state_next = DONE;
      DONE: begin
        mdu_valid_o  = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    if (mdu_kill_i) w_state_next = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // One iteration step; the top multiplier bit carries negative weight for signed rs2
  always_comb begin
    w_acc_step = r_acc;
    w_div_diff = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_mcand[XLEN-1:0]};
    if (r_state == MUL) begin
      if (r_b[0]) begin
        w_acc_step = (w_last && ((r_op == OP_MUL) || (r_op == OP_MULH))) ?
                     r_acc - r_mcand : r_acc + r_mcand;
      end
    end else if (r_state == DIV) begin
      w_acc_step = w_div_diff[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                    : {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    end
  end

  assign w_res_op  = (r_state == IDLE) ? mdu_op_i     : r_op;
  assign w_res_a   = (r_state == IDLE) ? mdu_port_a_i : r_a;
  assign w_res_b   = (r_state == IDLE) ? mdu_port_b_i : r_b;
  assign w_res_acc = (r_state == IDLE) ? w_early_acc  : w_acc_step;
  assign w_quo_raw = w_res_acc[XLEN-1:0];
  assign w_rem_raw = w_res_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_quo = w_quo_raw;
    w_rem = w_rem_raw;
    if (w_res_b == '0) begin
      w_quo = '1;
      w_rem = w_res_a;
    end else if ((w_res_op == OP_DIV) || (w_res_op == OP_REM)) begin
      if (w_res_a[XLEN-1] ^ w_res_b[XLEN-1]) w_quo = -w_quo_raw;
      if (w_res_a[XLEN-1])                   w_rem = -w_rem_raw;
    end
    if (!w_res_op[2]) w_result = (w_res_op == OP_MUL) ? w_res_acc[XLEN-1:0] : w_res_acc[2*XLEN-1:XLEN];
    else              w_result = w_res_op[1] ? w_rem : w_quo;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_op  <= mdu_op_i;
        r_a   <= mdu_port_a_i;
        r_b   <= mdu_port_b_i;
        r_cnt <= '0;
        if (mdu_op_i[2]) begin
          r_acc   <= {{XLEN{1'b0}}, w_a_abs};
          r_mcand <= {{XLEN{1'b0}}, w_b_abs};
        end else begin
          r_acc   <= '0;
          r_mcand <= {{XLEN{w_mul_a_sext}}, mdu_port_a_i};
        end
      end else if ((r_state == MUL) || (r_state == DIV)) begin
        r_acc <= w_acc_step;
        r_cnt <= r_cnt + 1'b1;
        if (r_state == MUL) begin
          r_mcand <= r_mcand << 1;
          r_b     <= r_b >> 1;
        end
      end
      if ((w_state_next == DONE) && (r_state != DONE)) r_result <= w_result;
    end
  end

  assign mdu_result_o = r_result;

endmodule

// File: tb/tb_miriscv_mdu.sv
// Scoreboard bench for miriscv_mdu: stimulus pushes expected results, a negedge monitor pops and checks.
module tb_miriscv_mdu;
  localparam int XLEN  = 32;
  localparam int NRAND = 1000;
`ifdef MIRISCV_MDU_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_i;
  logic            mdu_req_i;
  logic [2:0]      mdu_op_i;
  logic [XLEN-1:0] mdu_port_a_i;
  logic [XLEN-1:0] mdu_port_b_i;
  logic            mdu_kill_i;
  logic            mdu_ready_o;
  logic            mdu_valid_o;
  logic [XLEN-1:0] mdu_result_o;

  miriscv_mdu #(.XLEN(XLEN)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .mdu_req_i    (mdu_req_i),
    .mdu_op_i     (mdu_op_i),
    .mdu_port_a_i (mdu_port_a_i),
    .mdu_port_b_i (mdu_port_b_i),
    .mdu_kill_i   (mdu_kill_i),
    .mdu_ready_o  (mdu_ready_o),
    .mdu_valid_o  (mdu_valid_o),
    .mdu_result_o (mdu_result_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] res;
    int          exp_edge;
  } exp_t;

  exp_t sb_q[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   acc_edge;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_early(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'h0) || (((op == 3'd4) || (op == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
  endfunction

  function automatic int lat_of(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return (EO && is_early(op, a, b)) ? 0 : XLEN;
  endfunction

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic [63:0]        p;
    logic [31:0]        r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    r  = 32'h0;
    case (op)
      3'd0: begin p = {32'h0, a} * {32'h0, b}; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * $signed({32'h0, b}); r = p[63:32]; end
      3'd3: begin p = {32'h0, a} * {32'h0, b}; r = p[63:32]; end
      3'd4: if (b == 0) r = 32'hFFFF_FFFF; else begin p = sa / sb; r = p[31:0]; end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 0) r = a; else begin p = sa % sb; r = p[31:0]; end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Monitor: every valid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst_i && mdu_valid_o) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got result %h with no request outstanding (cycle %0d)", mdu_result_o, cyc);
      end else begin
        e = sb_q.pop_front();
        $display("txn op=%0d result=%h expected=%h edge=%0d expected_edge=%0d", e.op, mdu_result_o, e.res, cyc, e.exp_edge);
        check("result", mdu_result_o, e.res);
        check("latency_edge", cyc, e.exp_edge);
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit push);
    int waited = 0;
    exp_t e;
    @(negedge clk);
    while (!mdu_ready_o && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!mdu_ready_o) begin
      check("ready_timeout", {31'h0, mdu_ready_o}, 32'h1);
      return;
    end
    mdu_req_i = 1'b1;
    mdu_op_i = op;
    mdu_port_a_i = a;
    mdu_port_b_i = b;
    acc_edge = cyc + 1;
    if (push) begin
      e.op = op;
      e.res = exp;
      e.exp_edge = acc_edge + lat_of(op, a, b);
      sb_q.push_back(e);
    end
    @(negedge clk);
    mdu_req_i = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int   waited;
    int   last_acc;
    int   prev_lat;
    int   sel;
    exp_t e;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    rst_i = 1'b1;
    mdu_req_i = 1'b0;
    mdu_op_i = 3'd0;
    mdu_port_a_i = '0;
    mdu_port_b_i = '0;
    mdu_kill_i = 1'b0;
    idle_cycles(2);
    check("reset_ready", {31'h0, mdu_ready_o}, 32'h1);
    check("reset_valid", {31'h0, mdu_valid_o}, 32'h0);
    check("reset_result", mdu_result_o, 32'h0);
    rst_i = 1'b0;

    // Directed vectors, expected values hand-computed
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1);
    check("busy_not_ready", {31'h0, mdu_ready_o}, 32'h0);
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    issue(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1);
    issue(3'd1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1);
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    issue(3'd0, 32'd5, 32'd0, 32'd0, 1'b1);
    issue(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b1);
    issue(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b1);
    issue(3'd7, 32'd7, 32'd2, 32'd1, 1'b1);
    issue(3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1);
    issue(3'd6, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b1);
    issue(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
    issue(3'd6, 32'd5, 32'd0, 32'd5, 1'b1);
    issue(3'd4, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1'b1);
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1);

    // Kill in DONE keeps the pulse, then unit is idle and the result holds
    issue(3'd5, 32'd100, 32'd7, 32'd14, 1'b1);
    waited = 0;
    while (!mdu_valid_o && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("done_seen", {31'h0, mdu_valid_o}, 32'h1);
    mdu_kill_i = 1'b1;
    @(negedge clk);
    mdu_kill_i = 1'b0;
    check("kill_done_ready", {31'h0, mdu_ready_o}, 32'h1);
    idle_cycles(3);
    check("result_hold", mdu_result_o, 32'd14);

    // Kill ten cycles after acceptance: no pulse, then a fresh MUL works
    issue(3'd0, 32'd9, 32'd9, 32'd81, 1'b0);
    idle_cycles(9);
    mdu_kill_i = 1'b1;
    @(negedge clk);
    mdu_kill_i = 1'b0;
    check("kill_ready", {31'h0, mdu_ready_o}, 32'h1);
    idle_cycles(XLEN + 4);
    check("kill_result_hold", mdu_result_o, 32'd14);
    issue(3'd0, 32'd3, 32'd4, 32'd12, 1'b1);

    // Kill coincident with a request drops it
    @(negedge clk);
    while (!mdu_ready_o && cyc < 90000) @(negedge clk);
    mdu_req_i = 1'b1;
    mdu_kill_i = 1'b1;
    mdu_op_i = 3'd0;
    mdu_port_a_i = 32'd3;
    mdu_port_b_i = 32'd3;
    @(negedge clk);
    mdu_req_i = 1'b0;
    mdu_kill_i = 1'b0;
    check("kill_req_dropped", {31'h0, mdu_ready_o}, 32'h1);
    idle_cycles(XLEN + 4);
    check("kill_req_result", mdu_result_o, 32'd12);

    // Asynchronous reset mid-DIV
    issue(3'd5, 32'd1000, 32'd3, 32'd333, 1'b0);
    idle_cycles(5);
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_ready", {31'h0, mdu_ready_o}, 32'h1);
    check("async_rst_valid", {31'h0, mdu_valid_o}, 32'h0);
    check("async_rst_result", mdu_result_o, 32'h0);
    @(negedge clk);
    rst_i = 1'b0;
    idle_cycles(XLEN + 4);
    check("post_rst_result", mdu_result_o, 32'h0);

    // Back-to-back random ops with request held high; operands scrambled while busy
    @(negedge clk);
    mdu_req_i = 1'b1;
    last_acc = 0;
    prev_lat = 0;
    for (int i = 0; i < NRAND; i++) begin
      waited = 0;
      while (!mdu_ready_o && waited < 100) begin
        mdu_op_i = 3'($urandom_range(0, 7));
        mdu_port_a_i = $urandom;
        mdu_port_b_i = $urandom;
        @(negedge clk);
        waited++;
      end
      if (!mdu_ready_o) begin
        check("b2b_ready_timeout", {31'h0, mdu_ready_o}, 32'h1);
        break;
      end
      sel = $urandom_range(0, 15);
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      if (sel == 0) b = 32'h0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) begin a = $urandom_range(0, 100); b = $urandom_range(1, 10); end
      mdu_op_i = op;
      mdu_port_a_i = a;
      mdu_port_b_i = b;
      e.op = op;
      e.res = ref_model(op, a, b);
      e.exp_edge = cyc + 1 + lat_of(op, a, b);
      sb_q.push_back(e);
      if (i > 0) check("b2b_interval", cyc + 1 - last_acc, prev_lat + 2);
      last_acc = cyc + 1;
      prev_lat = lat_of(op, a, b);
      @(negedge clk);
    end
    mdu_req_i = 1'b0;

    waited = 0;
    while (sb_q.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("drain_outstanding", sb_q.size(), 32'h0);
    idle_cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
